// File: rtl/out_ctrl.sv
// Drains per-core results into dst_buf: issues one read strobe per channel with a
// strided address, then a one-cycle write-back tail with a done pulse.
module out_ctrl #(
    parameter int F_NUM = 16,
    parameter int OA_W  = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OA_W-1:0] base,
    input  logic [9:0]      os,
    input  logic [3:0]      od,
    input  logic            hold,
    output logic            outr,
    output logic [3:0]      ra,
    output logic [OA_W-1:0] oa,
    output logic            wv,
    output logic [OA_W-1:0] wa,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [3:0] OD_MAX = 4'(F_NUM - 1);

    state_t          state, state_nx;
    logic [3:0]      idx, idx_nx;
    logic [3:0]      od_l, od_l_nx;
    logic [OA_W-1:0] acc, acc_nx;
    logic [OA_W-1:0] base_l, base_l_nx;
    logic [9:0]      os_l, os_l_nx;
    logic            outr_nx, done_nx;
    logic [3:0]      ra_nx;
    logic [OA_W-1:0] oa_nx;
    logic [3:0]      od_clamp;

    assign od_clamp = (od > OD_MAX) ? OD_MAX : od;
    assign busy     = (state != IDLE);

    // Outputs are registered, so each decision prepares the next cycle's strobe:
    // idx/acc always point at the channel still waiting to be issued.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        acc_nx    = acc;
        od_l_nx   = od_l;
        base_l_nx = base_l;
        os_l_nx   = os_l;
        outr_nx   = 1'b0;
        ra_nx     = ra;
        oa_nx     = oa;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    base_l_nx = base;
                    os_l_nx   = os;
                    od_l_nx   = od_clamp;
                    outr_nx   = 1'b1;
                    ra_nx     = 4'd0;
                    oa_nx     = base;
                    idx_nx    = 4'd1;
                    acc_nx    = base + OA_W'(os);
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (outr && (ra == od_l)) begin
                    state_nx = DRAIN;
                    done_nx  = 1'b1;
                end else if (!hold) begin
                    outr_nx = 1'b1;
                    ra_nx   = idx;
                    oa_nx   = acc;
                    idx_nx  = idx + 4'd1;
                    acc_nx  = acc + OA_W'(os_l);
                end
            end
            DRAIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            od_l   <= '0;
            base_l <= '0;
            os_l   <= '0;
            outr   <= 1'b0;
            ra     <= '0;
            oa     <= '0;
            wv     <= 1'b0;
            wa     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            acc    <= acc_nx;
            od_l   <= od_l_nx;
            base_l <= base_l_nx;
            os_l   <= os_l_nx;
            outr   <= outr_nx;
            ra     <= ra_nx;
            oa     <= oa_nx;
            wv     <= outr;
            wa     <= oa;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_out_ctrl.sv
// Self-checking bench for out_ctrl: directed and random drains compared against a
// schedule computed from channel count, stride arithmetic and the hold pattern.
module tb_out_ctrl;

    localparam int F_NUM = 8;
    localparam int OA_W  = 13;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            hold = 1'b0;
    logic [OA_W-1:0] base = '0;
    logic [9:0]      os = '0;
    logic [3:0]      od = '0;
    logic            outr, wv, busy, done;
    logic [3:0]      ra;
    logic [OA_W-1:0] oa, wa;

    int              tests_run = 0;
    int              tests_failed = 0;
    logic [3:0]      prev_ra = '0;
    logic [OA_W-1:0] prev_oa = '0;

    out_ctrl #(.F_NUM(F_NUM), .OA_W(OA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .os(os), .od(od),
        .hold(hold), .outr(outr), .ra(ra), .oa(oa), .wv(wv), .wa(wa),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int cyc,
                               input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Channel k is read at (b + k*s) mod 2^OA_W. The first read follows start
    // unconditionally; every later read needs hold low in the cycle before it.
    task automatic applyStimulus(input logic [OA_W-1:0] b, input logic [9:0] s,
                                 input logic [3:0] d, input logic [63:0] hv,
                                 input int restart_cyc, input int reset_cyc);
        int n, last, end_cyc, c;
        int ic[16];
        logic [3:0]      cur_ra;
        logic [OA_W-1:0] cur_oa, last_oa;
        logic            exp_outr, last_outr;
        n = ((int'(d) > F_NUM - 1) ? F_NUM - 1 : int'(d)) + 1;
        ic[0] = 1;
        for (int k = 1; k < n; k++) begin
            c = ic[k-1] + 1;
            while (c <= 64 && hv[c-1]) c++;
            ic[k] = c;
        end
        last    = ic[n-1];
        end_cyc = (reset_cyc >= 0) ? reset_cyc + 4 : last + 2;
        cur_ra = prev_ra;
        cur_oa = prev_oa;
        last_oa = prev_oa;
        last_outr = 1'b0;
        for (int cy = 0; cy <= end_cyc; cy++) begin
            start = (cy == 0) || (cy == restart_cyc);
            base  = (cy == 0) ? b : ~b;
            os    = (cy == 0) ? s : ~s;
            od    = (cy == 0) ? d : ~d;
            hold  = (cy < 64) ? hv[cy] : 1'b0;
            reset = (cy == reset_cyc);
            exp_outr = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (ic[k] == cy) begin
                    exp_outr = 1'b1;
                    cur_ra = 4'(k);
                    cur_oa = OA_W'((int'(b) + k * int'(s)) % (1 << OA_W));
                end
            end
            @(negedge clk);
            if (reset_cyc >= 0 && cy > reset_cyc) begin
                checkOutput("abort_outr", cy, 16'(outr), 16'd0);
                checkOutput("abort_ra",   cy, 16'(ra),   16'd0);
                checkOutput("abort_oa",   cy, 16'(oa),   16'd0);
                checkOutput("abort_wv",   cy, 16'(wv),   16'd0);
                checkOutput("abort_wa",   cy, 16'(wa),   16'd0);
                checkOutput("abort_done", cy, 16'(done), 16'd0);
                checkOutput("abort_busy", cy, 16'(busy), 16'd0);
            end else begin
                checkOutput("outr", cy, 16'(outr), 16'(exp_outr));
                checkOutput("ra",   cy, 16'(ra),   16'(cur_ra));
                checkOutput("oa",   cy, 16'(oa),   16'(cur_oa));
                checkOutput("wv",   cy, 16'(wv),   16'(last_outr));
                checkOutput("wa",   cy, 16'(wa),   16'(last_oa));
                checkOutput("done", cy, 16'(done), 16'(cy == last + 1));
                checkOutput("busy", cy, 16'(busy), 16'(cy >= 1 && cy <= last + 1));
            end
            last_outr = exp_outr;
            last_oa   = cur_oa;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
        hold  = 1'b0;
        if (reset_cyc >= 0) begin
            prev_ra = '0;
            prev_oa = '0;
        end else begin
            prev_ra = cur_ra;
            prev_oa = cur_oa;
        end
    endtask

    initial begin
        logic [63:0] hv;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_outr", 0, 16'(outr), 16'd0);
        checkOutput("rst_ra",   0, 16'(ra),   16'd0);
        checkOutput("rst_oa",   0, 16'(oa),   16'd0);
        checkOutput("rst_wv",   0, 16'(wv),   16'd0);
        checkOutput("rst_wa",   0, 16'(wa),   16'd0);
        checkOutput("rst_done", 0, 16'(done), 16'd0);
        checkOutput("rst_busy", 0, 16'(busy), 16'd0);
        @(posedge clk);
        #1;

        $display("[TB] basic drain of 4 channels");
        applyStimulus(13'h100, 10'h40, 4'd3, 64'h0, -1, -1);
        $display("[TB] hold after second read, start together with hold");
        applyStimulus(13'h100, 10'h40, 4'd3, 64'hD, -1, -1);
        $display("[TB] address wrap");
        applyStimulus(13'h1FF0, 10'h20, 4'd1, 64'h0, -1, -1);
        $display("[TB] od clamp to F_NUM-1");
        applyStimulus(13'h0A5, 10'h3FF, 4'd15, 64'h0, -1, -1);
        $display("[TB] single channel");
        applyStimulus(13'h0777, 10'h011, 4'd0, 64'h0, -1, -1);
        $display("[TB] start re-pulsed while running");
        applyStimulus(13'h0200, 10'h008, 4'd3, 64'h0, 2, -1);
        $display("[TB] reset at third read");
        applyStimulus(13'h0300, 10'h010, 4'd5, 64'h0, -1, 3);

        $display("[TB] random drains");
        for (int i = 0; i < 10; i++) begin
            hv = {32'h0, $urandom() & $urandom()};
            applyStimulus(OA_W'($urandom()), 10'($urandom()), 4'($urandom()), hv, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
